// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the RAM.
// slave = arbiter side, master = requester/RAM environment side.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic [STRB_W-1:0] m0_wstrb;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic [STRB_W-1:0] m1_wstrb;
    logic              m1_lock;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [DATA_W-1:0] m1_rdata;

    logic              ram_en;
    logic [STRB_W-1:0] ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb, m1_lock,
        output m1_gnt, m1_rvalid, m1_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb, m1_lock,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin share of one single-port data RAM between CPU (port 0) and debug/loader (port 1).
// Grant is combinational in the request cycle; read data returns RD_LAT cycles later; losers simply hold req.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);
    localparam int STRB_W = DATA_W / 8;

    logic              prio;
    logic              last;
    logic              winner;
    logic              grant_any;
    logic              win_we;
    logic [STRB_W-1:0] win_strb;
    logic [RD_LAT-1:0] tag_vld;
    logic [RD_LAT-1:0] tag_port;

    always_comb begin
        // Grants are held off while in reset even if requests are already up.
        grant_any = rst && (bus.m0_req || bus.m1_req);
        winner    = 1'b0;
        if (bus.m1_req) begin
            if (last && bus.m1_lock) begin
                winner = 1'b1;
            end else if (!bus.m0_req) begin
                winner = 1'b1;
            end else begin
                winner = prio;
            end
        end
        win_we   = winner ? bus.m1_we    : bus.m0_we;
        win_strb = winner ? bus.m1_wstrb : bus.m0_wstrb;
    end

    assign bus.m0_gnt    = grant_any && !winner;
    assign bus.m1_gnt    = grant_any && winner;
    assign bus.ram_en    = grant_any;
    assign bus.ram_addr  = winner ? bus.m1_addr  : bus.m0_addr;
    assign bus.ram_wdata = winner ? bus.m1_wdata : bus.m0_wdata;
    assign bus.ram_we    = (grant_any && win_we) ? win_strb : '0;

    // The tag tail lines up with ram_rdata, so rvalid steers the shared data bus.
    assign bus.m0_rvalid = tag_vld[RD_LAT-1] && !tag_port[RD_LAT-1];
    assign bus.m1_rvalid = tag_vld[RD_LAT-1] &&  tag_port[RD_LAT-1];
    assign bus.m0_rdata  = bus.ram_rdata;
    assign bus.m1_rdata  = bus.ram_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio <= 1'b0;
            last <= 1'b0;
        end else if (grant_any) begin
            prio <= ~winner;
            last <= winner;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_vld  <= '0;
            tag_port <= '0;
        end else begin
            tag_vld[0]  <= grant_any && !win_we;
            tag_port[0] <= winner;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_vld[i]  <= tag_vld[i-1];
                tag_port[i] <= tag_port[i-1];
            end
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: one instance at RD_LAT=1 driven from a vector table, one at RD_LAT=3
// for the latency and mid-read reset sequences; each has a small behavioural RAM.
module tb_dmem_arbiter;
    localparam logic T = 1'b1;
    localparam logic F = 1'b0;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM models: word index from addr[7:2], contents 0x5A00_0000 | index after reset.
    logic [31:0] mem1 [64];
    logic [31:0] rd1;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) mem1[i] <= 32'h5A00_0000 | i;
            rd1 <= '0;
        end else if (bus1.ram_en) begin
            if (bus1.ram_we != 4'b0000) begin
                for (int b = 0; b < 4; b++)
                    if (bus1.ram_we[b]) mem1[bus1.ram_addr[7:2]][8*b +: 8] <= bus1.ram_wdata[8*b +: 8];
            end else begin
                rd1 <= mem1[bus1.ram_addr[7:2]];
            end
        end
    end
    assign bus1.ram_rdata = rd1;

    logic [31:0] mem3 [64];
    logic [31:0] p3 [3];
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) mem3[i] <= 32'h5A00_0000 | i;
            for (int i = 0; i < 3; i++) p3[i] <= '0;
        end else begin
            p3[0] <= (bus3.ram_en && bus3.ram_we == 4'b0000) ? mem3[bus3.ram_addr[7:2]] : 32'h0;
            p3[1] <= p3[0];
            p3[2] <= p3[1];
            if (bus3.ram_en && bus3.ram_we != 4'b0000)
                for (int b = 0; b < 4; b++)
                    if (bus3.ram_we[b]) mem3[bus3.ram_addr[7:2]][8*b +: 8] <= bus3.ram_wdata[8*b +: 8];
        end
    end
    assign bus3.ram_rdata = p3[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        r0; logic w0; logic [31:0] a0;
        logic        r1; logic w1; logic [31:0] a1; logic [31:0] d1; logic [3:0] s1; logic lk;
        logic        g0; logic g1; logic en; logic [3:0] we; logic [31:0] addr;
        logic        rv0; logic rv1; logic [31:0] rd;
    } vec_t;

    vec_t vecs [17];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b0;
        {bus1.m0_req, bus1.m0_we, bus1.m1_req, bus1.m1_we, bus1.m1_lock} = '0;
        {bus3.m0_req, bus3.m0_we, bus3.m1_req, bus3.m1_we, bus3.m1_lock} = '0;
        bus1.m0_addr = '0; bus1.m0_wdata = '0; bus1.m0_wstrb = '0;
        bus1.m1_addr = '0; bus1.m1_wdata = '0; bus1.m1_wstrb = '0;
        bus3.m0_addr = '0; bus3.m0_wdata = '0; bus3.m0_wstrb = '0;
        bus3.m1_addr = '0; bus3.m1_wdata = '0; bus3.m1_wstrb = '0;

        //            r0 w0 a0      r1 w1 a1      d1            s1     lk  g0 g1 en we     addr     rv0 rv1 rd
        vecs[0]  = '{F, F, 32'h00, F, F, 32'h00, 32'h0,        4'h0,  F,  F, F, F, 4'h0,  32'h00,  F, F, 32'h0};
        vecs[1]  = '{T, F, 32'h10, T, F, 32'h20, 32'h0,        4'h0,  F,  T, F, T, 4'h0,  32'h10,  F, F, 32'h0};
        vecs[2]  = '{T, F, 32'h10, T, F, 32'h20, 32'h0,        4'h0,  F,  F, T, T, 4'h0,  32'h20,  T, F, 32'h5A000004};
        vecs[3]  = '{T, F, 32'h10, T, F, 32'h20, 32'h0,        4'h0,  F,  T, F, T, 4'h0,  32'h10,  F, T, 32'h5A000008};
        vecs[4]  = '{T, F, 32'h10, T, F, 32'h20, 32'h0,        4'h0,  F,  F, T, T, 4'h0,  32'h20,  T, F, 32'h5A000004};
        vecs[5]  = '{T, F, 32'h10, T, F, 32'h20, 32'h0,        4'h0,  T,  F, T, T, 4'h0,  32'h20,  F, T, 32'h5A000008};
        vecs[6]  = '{T, F, 32'h10, T, F, 32'h20, 32'h0,        4'h0,  T,  F, T, T, 4'h0,  32'h20,  F, T, 32'h5A000008};
        vecs[7]  = '{T, F, 32'h10, T, F, 32'h20, 32'h0,        4'h0,  T,  F, T, T, 4'h0,  32'h20,  F, T, 32'h5A000008};
        vecs[8]  = '{T, F, 32'h10, T, F, 32'h20, 32'h0,        4'h0,  T,  F, T, T, 4'h0,  32'h20,  F, T, 32'h5A000008};
        vecs[9]  = '{T, F, 32'h10, T, F, 32'h20, 32'h0,        4'h0,  F,  T, F, T, 4'h0,  32'h10,  F, T, 32'h5A000008};
        vecs[10] = '{F, F, 32'h00, F, F, 32'h00, 32'h0,        4'h0,  F,  F, F, F, 4'h0,  32'h00,  T, F, 32'h5A000004};
        vecs[11] = '{F, F, 32'h00, T, T, 32'h40, 32'hDEADBEEF, 4'h3,  F,  F, T, T, 4'h3,  32'h40,  F, F, 32'h0};
        vecs[12] = '{T, F, 32'h40, F, F, 32'h00, 32'h0,        4'h0,  F,  T, F, T, 4'h0,  32'h40,  F, F, 32'h0};
        vecs[13] = '{F, F, 32'h00, F, F, 32'h00, 32'h0,        4'h0,  F,  F, F, F, 4'h0,  32'h00,  T, F, 32'h5A00BEEF};
        vecs[14] = '{F, F, 32'h00, T, F, 32'h20, 32'h0,        4'h0,  T,  F, T, T, 4'h0,  32'h20,  F, F, 32'h0};
        vecs[15] = '{T, F, 32'h10, F, F, 32'h00, 32'h0,        4'h0,  T,  T, F, T, 4'h0,  32'h10,  F, T, 32'h5A000008};
        vecs[16] = '{F, F, 32'h00, F, F, 32'h00, 32'h0,        4'h0,  F,  F, F, F, 4'h0,  32'h00,  T, F, 32'h5A000004};

        // Reset with both requests raised: nothing may be granted or strobed.
        bus1.m0_req = 1'b1; bus1.m1_req = 1'b1;
        bus3.m0_req = 1'b1; bus3.m1_req = 1'b1;
        #3;
        check("rst_gnt0",   32'(bus1.m0_gnt),    32'h0);
        check("rst_gnt1",   32'(bus1.m1_gnt),    32'h0);
        check("rst_ram_en", 32'(bus1.ram_en),    32'h0);
        check("rst_ram_we", 32'(bus1.ram_we),    32'h0);
        check("rst_rv0",    32'(bus1.m0_rvalid), 32'h0);
        check("rst_rv1",    32'(bus1.m1_rvalid), 32'h0);
        check("rst3_gnt0",  32'(bus3.m0_gnt),    32'h0);
        check("rst3_gnt1",  32'(bus3.m1_gnt),    32'h0);
        @(negedge clk);
        bus1.m0_req = 1'b0; bus1.m1_req = 1'b0;
        bus3.m0_req = 1'b0; bus3.m1_req = 1'b0;
        rst = 1'b1;

        for (int v = 0; v < 17; v++) begin
            @(negedge clk);
            bus1.m0_req   = vecs[v].r0; bus1.m0_we = vecs[v].w0; bus1.m0_addr = vecs[v].a0;
            bus1.m1_req   = vecs[v].r1; bus1.m1_we = vecs[v].w1; bus1.m1_addr = vecs[v].a1;
            bus1.m1_wdata = vecs[v].d1; bus1.m1_wstrb = vecs[v].s1; bus1.m1_lock = vecs[v].lk;
            #2;
            check($sformatf("v%0d_gnt0", v),   32'(bus1.m0_gnt),    32'(vecs[v].g0));
            check($sformatf("v%0d_gnt1", v),   32'(bus1.m1_gnt),    32'(vecs[v].g1));
            check($sformatf("v%0d_ram_en", v), 32'(bus1.ram_en),    32'(vecs[v].en));
            check($sformatf("v%0d_ram_we", v), 32'(bus1.ram_we),    32'(vecs[v].we));
            check($sformatf("v%0d_rv0", v),    32'(bus1.m0_rvalid), 32'(vecs[v].rv0));
            check($sformatf("v%0d_rv1", v),    32'(bus1.m1_rvalid), 32'(vecs[v].rv1));
            if (vecs[v].en)
                check($sformatf("v%0d_ram_addr", v), bus1.ram_addr, vecs[v].addr);
            if (vecs[v].we != 4'h0)
                check($sformatf("v%0d_ram_wdata", v), bus1.ram_wdata, vecs[v].d1);
            if (vecs[v].rv0)
                check($sformatf("v%0d_m0_rdata", v), bus1.m0_rdata, vecs[v].rd);
            if (vecs[v].rv1)
                check($sformatf("v%0d_m1_rdata", v), bus1.m1_rdata, vecs[v].rd);
        end
        @(negedge clk);
        {bus1.m0_req, bus1.m1_req, bus1.m1_we, bus1.m1_lock} = '0;

        // RD_LAT=3: four back-to-back m0 reads return on four consecutive cycles, 3 after each grant.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus3.m0_req  = (i < 4);
            bus3.m0_addr = 32'(i * 4);
            #2;
            check($sformatf("lat_c%0d_gnt0", i), 32'(bus3.m0_gnt),    32'(i < 4));
            check($sformatf("lat_c%0d_rv0", i),  32'(bus3.m0_rvalid), 32'(i >= 3 && i < 7));
            check($sformatf("lat_c%0d_rv1", i),  32'(bus3.m1_rvalid), 32'h0);
            if (i >= 3 && i < 7)
                check($sformatf("lat_c%0d_rdata", i), bus3.m0_rdata, 32'h5A00_0000 | 32'(i - 3));
        end

        // Reset one cycle after a read is granted: the pending tag must never surface.
        @(negedge clk);
        bus3.m0_req = 1'b1; bus3.m0_addr = 32'h10;
        #2;
        check("mid_rst_gnt0", 32'(bus3.m0_gnt), 32'h1);
        @(negedge clk);
        bus3.m0_req = 1'b0;
        rst = 1'b0;
        #2;
        check("mid_rst_rv0_in_reset", 32'(bus3.m0_rvalid), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #2;
            check($sformatf("post_rst_c%0d_rv0", i), 32'(bus3.m0_rvalid), 32'h0);
            check($sformatf("post_rst_c%0d_rv1", i), 32'(bus3.m1_rvalid), 32'h0);
        end
        @(negedge clk);
        bus3.m1_req = 1'b1; bus3.m1_addr = 32'h20;
        #2;
        check("post_rst_gnt1", 32'(bus3.m1_gnt), 32'h1);
        check("post_rst_gnt0", 32'(bus3.m0_gnt), 32'h0);
        @(negedge clk);
        bus3.m1_req = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            if (j > 1) @(negedge clk);
            #2;
            check($sformatf("post_rst_ret%0d_rv1", j), 32'(bus3.m1_rvalid), 32'(j == 3));
            if (j == 3)
                check("post_rst_rdata", bus3.m1_rdata, 32'h5A00_0008);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
